// File: rtl/pipe_pkg.sv
// pipe_pkg -- shared definitions for the pipeline hazard controller.
//   REG_W      : architectural register-number width
//   MD_CYCLES  : number of cycles a mul/div occupies the EX stage
//   MD_CNT_W   : width of the mul/div countdown
//   state_e    : controller state (RUN, MD_BUSY)
package pipe_pkg;

    localparam int REG_W     = 5;
    localparam int MD_CYCLES = 32;
    localparam int MD_CNT_W  = 5;

    typedef enum logic {
        RUN     = 1'b0,
        MD_BUSY = 1'b1
    } state_e;

endpackage

// File: rtl/md_busy_cnt.sv
// md_busy_cnt -- mul/div occupancy countdown.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : load MD_CYCLES-1 (takes priority over dec)
//   dec        : decrement by one, holding at zero
//   cnt        : current count
//   zero       : count is zero
module md_busy_cnt
    import pipe_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic                dec,
    output logic [MD_CNT_W-1:0] cnt,
    output logic                zero
);

    // NOTE: sequential state is written with non-blocking assignments so every
    // flop samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= MD_CNT_W'(MD_CYCLES - 1);
        end else if (dec && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl -- stall/flush control for a 5-stage pipeline.
// Handles data-memory wait (global freeze), taken-branch flush, load-use
// interlock and, optionally, a multi-cycle mul/div occupying EX.
// Build option: define PIPE_HAZARD_CTRL_MULDIV_EN to implement the MD_BUSY
// state, its countdown and md_busy; otherwise md_start is ignored.
// Ports:
//   clk, rst_n                        : clock, asynchronous active-low reset
//   id_rs, id_rt, id_uses_rt          : ID-stage source registers
//   ex_mem_read, ex_rd                : EX-stage load and its destination
//   branch_taken, md_start            : EX-stage branch outcome, mul/div issue
//   dmem_req, dmem_ready              : MEM-stage memory handshake
//   pc_wr .. mem_wb_wr                : pipeline register write enables
//   if_id_flush..ex_mem_flush         : bubble insertion
//   md_busy                           : mul/div in progress
//   stall_cycles                      : saturating count of cycles with pc_wr=0
module pipe_hazard_ctrl
    import pipe_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             branch_taken,
    input  logic             md_start,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             pc_wr,
    output logic             if_id_wr,
    output logic             id_ex_wr,
    output logic             ex_mem_wr,
    output logic             mem_wb_wr,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             ex_mem_flush,
    output logic             md_busy,
    output logic [15:0]      stall_cycles
);

    logic   memwait;
    logic   load_use;
    state_e state;

    assign memwait  = dmem_req & ~dmem_ready;
    // Register 0 is hard-wired zero, so a load targeting it never creates a hazard.
    assign load_use = ex_mem_read && (ex_rd != '0) &&
                      ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));

`ifdef PIPE_HAZARD_CTRL_MULDIV_EN
    state_e state_nxt;
    logic   md_load;
    logic   md_zero;
    logic [MD_CNT_W-1:0] md_cnt_unused;

    // A mul/div issued while memory is stalling is not accepted; EX holds it
    // and md_start is seen again once the freeze lifts.
    assign md_load = (state == RUN) && md_start && !memwait;

    md_busy_cnt u_md_busy_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (md_load),
        .dec   (state == MD_BUSY),
        .cnt   (md_cnt_unused),
        .zero  (md_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= RUN;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            RUN:     if (md_load) state_nxt = MD_BUSY;
            MD_BUSY: if (md_zero) state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
    end

    assign md_busy = (state == MD_BUSY);
`else
    logic md_start_unused;

    assign md_start_unused = md_start;
    assign state           = RUN;
    assign md_busy         = 1'b0;
`endif

    // NOTE: every output gets its default before the priority chain so no path
    // leaves a signal unassigned, which would infer a latch.
    always_comb begin
        pc_wr        = 1'b1;
        if_id_wr     = 1'b1;
        id_ex_wr     = 1'b1;
        ex_mem_wr    = 1'b1;
        mem_wb_wr    = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        if (memwait) begin
            // Whole pipeline freezes; nothing advances and nothing is flushed.
            pc_wr     = 1'b0;
            if_id_wr  = 1'b0;
            id_ex_wr  = 1'b0;
            ex_mem_wr = 1'b0;
            mem_wb_wr = 1'b0;
        end else if (state == MD_BUSY) begin
            // Front end holds; bubbles go into EX/MEM while MEM/WB drains.
            pc_wr        = 1'b0;
            if_id_wr     = 1'b0;
            id_ex_wr     = 1'b0;
            ex_mem_wr    = 1'b0;
            ex_mem_flush = 1'b1;
        end else if (branch_taken) begin
            // The stalled consumer is on the wrong path, so the flush wins.
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (load_use) begin
            pc_wr       = 1'b0;
            if_id_wr    = 1'b0;
            id_ex_flush = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= '0;
        end else if (!pc_wr && stall_cycles != 16'hFFFF) begin
            stall_cycles <= stall_cycles + 16'd1;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl -- directed, table-driven bench for pipe_hazard_ctrl.
// Output bundle order: {pc_wr, if_id_wr, id_ex_wr, ex_mem_wr, mem_wb_wr,
//                       if_id_flush, id_ex_flush, ex_mem_flush}.
module tb_pipe_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [4:0]  id_rs = '0;
    logic [4:0]  id_rt = '0;
    logic        id_uses_rt = 1'b0;
    logic        ex_mem_read = 1'b0;
    logic [4:0]  ex_rd = '0;
    logic        branch_taken = 1'b0;
    logic        md_start = 1'b0;
    logic        dmem_req = 1'b0;
    logic        dmem_ready = 1'b0;
    logic        pc_wr, if_id_wr, id_ex_wr, ex_mem_wr, mem_wb_wr;
    logic        if_id_flush, id_ex_flush, ex_mem_flush;
    logic        md_busy;
    logic [15:0] stall_cycles;
    logic [7:0]  outs;

    int checks = 0;
    int errors = 0;

    localparam logic [7:0] ALL_RUN   = 8'b11111_000;
    localparam logic [7:0] LOAD_USE  = 8'b00111_010;
    localparam logic [7:0] BR_FLUSH  = 8'b11111_110;
    localparam logic [7:0] FREEZE    = 8'b00000_000;
    localparam logic [7:0] MD_HOLD   = 8'b00001_001;

    always #5 clk = ~clk;

    pipe_hazard_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_uses_rt   (id_uses_rt),
        .ex_mem_read  (ex_mem_read),
        .ex_rd        (ex_rd),
        .branch_taken (branch_taken),
        .md_start     (md_start),
        .dmem_req     (dmem_req),
        .dmem_ready   (dmem_ready),
        .pc_wr        (pc_wr),
        .if_id_wr     (if_id_wr),
        .id_ex_wr     (id_ex_wr),
        .ex_mem_wr    (ex_mem_wr),
        .mem_wb_wr    (mem_wb_wr),
        .if_id_flush  (if_id_flush),
        .id_ex_flush  (id_ex_flush),
        .ex_mem_flush (ex_mem_flush),
        .md_busy      (md_busy),
        .stall_cycles (stall_cycles)
    );

    assign outs = {pc_wr, if_id_wr, id_ex_wr, ex_mem_wr, mem_wb_wr,
                   if_id_flush, id_ex_flush, ex_mem_flush};

    typedef struct {
        string      name;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       uses_rt;
        logic       mem_read;
        logic [4:0] rd;
        logic       br;
        logic       dreq;
        logic       drdy;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        id_rs = '0; id_rt = '0; id_uses_rt = 1'b0; ex_mem_read = 1'b0; ex_rd = '0;
        branch_taken = 1'b0; md_start = 1'b0; dmem_req = 1'b0; dmem_ready = 1'b0;
    endtask

    // Leaves rst_n high at a falling edge with no rising edge seen since release.
    task automatic reset_dut();
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int n_stall;

        vecs[0]  = '{"idle",          5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, ALL_RUN};
        vecs[1]  = '{"lu_rs",         5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, LOAD_USE};
        vecs[2]  = '{"rd_zero",       5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, ALL_RUN};
        vecs[3]  = '{"lu_rt",         5'd3, 5'd7, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, LOAD_USE};
        vecs[4]  = '{"rt_not_used",   5'd3, 5'd7, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, ALL_RUN};
        vecs[5]  = '{"no_match",      5'd3, 5'd4, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, ALL_RUN};
        vecs[6]  = '{"not_load",      5'd5, 5'd0, 1'b0, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0, ALL_RUN};
        vecs[7]  = '{"br_over_lu",    5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, BR_FLUSH};
        vecs[8]  = '{"br_only",       5'd1, 5'd2, 1'b1, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0, BR_FLUSH};
        vecs[9]  = '{"memwait_all",   5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, FREEZE};
        vecs[10] = '{"mem_ready",     5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, ALL_RUN};
        vecs[11] = '{"ready_no_req",  5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, ALL_RUN};

        // Reset state, sampled while rst_n is still low.
        #2;
        check("reset_outs", 32'(outs), 32'(ALL_RUN));
        check("reset_md_busy", 32'(md_busy), 32'd0);
        check("reset_stall", 32'(stall_cycles), 32'd0);
        reset_dut();

        // Table: one vector per cycle; every vector with pc_wr=0 adds a stall.
        n_stall = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            id_rs = vecs[i].rs; id_rt = vecs[i].rt; id_uses_rt = vecs[i].uses_rt;
            ex_mem_read = vecs[i].mem_read; ex_rd = vecs[i].rd; branch_taken = vecs[i].br;
            dmem_req = vecs[i].dreq; dmem_ready = vecs[i].drdy;
            #1;
            check(vecs[i].name, 32'(outs), 32'(vecs[i].exp));
            if (!vecs[i].exp[7]) n_stall++;
        end
        @(negedge clk);
        idle_inputs();
        #1;
        check("table_stall_count", 32'(stall_cycles), 32'(n_stall));

        // Single load-use: one stall cycle, then back to running.
        reset_dut();
        @(negedge clk);
        ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs = 5'd5;
        #1;
        check("lu_seq_outs", 32'(outs), 32'(LOAD_USE));
        @(negedge clk);
        idle_inputs();
        #1;
        check("lu_seq_after", 32'(outs), 32'(ALL_RUN));
        check("lu_seq_stall", 32'(stall_cycles), 32'd1);

        // Three cycles of memory wait, then ready.
        reset_dut();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            dmem_req = 1'b1; dmem_ready = 1'b0;
            #1;
            check($sformatf("memwait_c%0d", i), 32'(outs), 32'(FREEZE));
        end
        @(negedge clk);
        dmem_ready = 1'b1;
        #1;
        check("memwait_done", 32'(outs), 32'(ALL_RUN));
        check("memwait_stall", 32'(stall_cycles), 32'd3);

`ifdef PIPE_HAZARD_CTRL_MULDIV_EN
        // md_start during memwait is not accepted.
        reset_dut();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            md_start = 1'b1; dmem_req = 1'b1; dmem_ready = 1'b0;
        end
        @(negedge clk);
        idle_inputs();
        #1;
        check("md_ignored_memwait", 32'(md_busy), 32'd0);

        // Full mul/div: 32 busy cycles, memwait on busy cycles 10..12 still counts down.
        reset_dut();
        @(negedge clk);
        md_start = 1'b1;
        #1;
        check("md_issue_cycle", 32'({md_busy, outs}), 32'({1'b0, ALL_RUN}));
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            idle_inputs();
            // Hazards must be ignored while busy.
            branch_taken = 1'b1; ex_mem_read = 1'b1; ex_rd = 5'd4; id_rs = 5'd4;
            if (i >= 10 && i <= 12) begin
                dmem_req = 1'b1; dmem_ready = 1'b0;
            end
            #1;
            check($sformatf("md_busy_c%0d", i), 32'({md_busy, outs}),
                  32'({1'b1, (i >= 10 && i <= 12) ? FREEZE : MD_HOLD}));
        end
        @(negedge clk);
        idle_inputs();
        #1;
        check("md_back_to_run", 32'({md_busy, outs}), 32'({1'b0, ALL_RUN}));
        check("md_stall_count", 32'(stall_cycles), 32'd32);

        // Reset in the middle of a busy sequence aborts it immediately.
        reset_dut();
        @(negedge clk);
        md_start = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            md_start = 1'b0;
        end
        #1;
        check("md_abort_pre", 32'(md_busy), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("md_abort_busy", 32'(md_busy), 32'd0);
        check("md_abort_outs", 32'(outs), 32'(ALL_RUN));
        check("md_abort_stall", 32'(stall_cycles), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        check("md_abort_stays_run", 32'(md_busy), 32'd0);
`else
        // Without the mul/div option, md_start has no effect.
        reset_dut();
        @(negedge clk);
        md_start = 1'b1;
        #1;
        check("md_off_issue", 32'(outs), 32'(ALL_RUN));
        @(negedge clk);
        md_start = 1'b0;
        #1;
        check("md_off_busy", 32'({md_busy, outs}), 32'({1'b0, ALL_RUN}));
        check("md_off_stall", 32'(stall_cycles), 32'd0);
`endif

        // Long freeze drives stall_cycles into saturation.
        reset_dut();
        @(negedge clk);
        dmem_req = 1'b1; dmem_ready = 1'b0;
        for (int i = 0; i < 70000; i++) @(posedge clk);
        @(negedge clk);
        check("stall_saturate", 32'(stall_cycles), 32'h0000FFFF);
        @(negedge clk);
        check("stall_saturate_hold", 32'(stall_cycles), 32'h0000FFFF);
        idle_inputs();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have ports, in order:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
REQ-002 SHALL have ID-stage inputs:
- id_rs  in  5  source register rs of the instruction in ID
- id_rt  in  5  source register rt of the instruction in ID
- id_uses_rt  in  1  ID instruction reads rt
REQ-003 SHALL have EX-stage inputs:
- ex_mem_read  in  1  EX instruction is a load
- ex_rd  in  5  destination register of the EX instruction
- branch_taken  in  1  branch resolved taken in EX
- md_start  in  1  mul/div issued in EX
REQ-004 SHALL have MEM-stage inputs:
- dmem_req  in  1  MEM stage is accessing data memory
- dmem_ready  in  1  data memory completes this cycle
REQ-005 SHALL have outputs:
- pc_wr, if_id_wr, id_ex_wr, ex_mem_wr, mem_wb_wr  out  1 each  write enables driving the IRWr of each pipeline register
- if_id_flush, id_ex_flush, ex_mem_flush  out  1 each  load a bubble into the named register
- md_busy  out  1  high while in MD_BUSY
- stall_cycles  out  16  saturating count of cycles with pc_wr=0

Function
REQ-006 SHALL hold a state register with states RUN, MD_BUSY and a 5-bit md counter; all enable and flush outputs SHALL be combinational from state, counter and current inputs.
REQ-007 Default in RUN with no hazard SHALL be all *_wr=1 and all *_flush=0.
REQ-008 memwait = dmem_req & ~dmem_ready SHALL force all *_wr=0 and all *_flush=0 in every state, with highest priority.
REQ-009 In RUN, branch_taken (without memwait) SHALL set if_id_flush=1 and id_ex_flush=1 with pc_wr=1, overriding any load-use stall.
REQ-010 Load-use SHALL be detected as ex_mem_read & ex_rd!=0 & (ex_rd==id_rs | (id_uses_rt & ex_rd==id_rt)).
REQ-011 A load-use in RUN (without memwait or branch) SHALL set pc_wr=0, if_id_wr=0 and id_ex_flush=1, with the other enables at 1, for exactly one cycle.
REQ-012 md_start in RUN without memwait SHALL, at the clock edge, move the state to MD_BUSY and load the counter with MD_CYCLES-1; with memwait, md_start SHALL be ignored until memwait clears.
REQ-013 In MD_BUSY, the enables SHALL be:
- pc_wr, if_id_wr, id_ex_wr, ex_mem_wr = 0
- ex_mem_flush = 1
- mem_wb_wr = 1 (MEM/WB drains)
REQ-014 In MD_BUSY, the counter SHALL decrement every cycle, including during memwait.
REQ-015 In MD_BUSY with the counter at 0, the state SHALL return to RUN at the next edge, and RUN rules SHALL apply from that cycle.
REQ-016 branch_taken and load-use SHALL be ignored in MD_BUSY.
REQ-017 stall_cycles SHALL increment on every edge where pc_wr=0, and SHALL saturate at 16'hFFFF.

Reset
REQ-018 When rst_n=0, the block SHALL immediately, independent of clk, set state=RUN, md counter=0 and stall_cycles=0, giving md_busy=0 and RUN combinational outputs; reset SHALL abort an MD_BUSY sequence.
REQ-019 The first edge after rst_n rises SHALL be evaluated as RUN.

Configuration
REQ-020 With macro PIPE_HAZARD_CTRL_MULDIV_EN defined, the MD_BUSY state, the md counter and md_busy SHALL be implemented.
REQ-021 Without PIPE_HAZARD_CTRL_MULDIV_EN, md_start SHALL be ignored, md_busy SHALL be tied to 0, and the state SHALL remain RUN.

Structure
REQ-022 Shared package pipe_pkg SHALL hold:
- the state enum (RUN, MD_BUSY)
- MD_CYCLES=32
- the register-number width 5
REQ-023 The md countdown SHALL be a sub-module md_busy_cnt (load, decrement, zero flag); the hazard decode SHALL stay in the top module.

Verification
REQ-024 Load at EX with ex_rd=5 and id_rs=5 -> one cycle of pc_wr=0, if_id_wr=0, id_ex_flush=1; stall_cycles=1.
REQ-025 ex_rd=0 with ex_mem_read=1 and id_rs=0 -> no stall; all enables 1.
REQ-026 branch_taken=1 together with a load-use match -> if_id_flush=1, id_ex_flush=1, pc_wr=1.
REQ-027 dmem_req=1 with dmem_ready=0 for 3 cycles, then 1 -> all enables 0 for 3 cycles, then all 1; stall_cycles=3.
REQ-028 With MULDIV_EN, md_start pulse -> md_busy high for 32 cycles, ex_mem_flush=1 throughout, then RUN; rst_n low at busy cycle 10 -> md_busy=0 immediately.
REQ-029 stall_cycles preset near saturation through a 70000-cycle memwait -> stall_cycles holds at 16'hFFFF.
